lsu_mem: RTL and testbench
==========================

# lsu_mem

Parametrised, multi-cycle load/store unit that sits between the core's memory stage and a handshaked data-memory port. It accepts one load or store per request, performs sign/zero extension and byte-lane steering for XLEN = 32 or 64, and splits misaligned accesses that cross a word boundary into two aligned memory beats. Completion, including store completion, is reported through a response handshake so the core can stall on variable memory latency.

## Interface
- XLEN, default 32: data width, either 32 or 64; word size W = XLEN/8 bytes.
- ADDR_W, default 32: address width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- ReqValid  in  1  request valid.
- ReqReady  out  1  unit idle and able to accept a request.
- MemRd  in  1  load request.
- MemWr  in  1  store request.
- MemOp  in  3  access type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- Addr  in  ADDR_W  byte address.
- WData  in  XLEN  store data, least-significant bytes used.
- RespValid  out  1  response valid.
- RespReady  in  1  response accepted.
- RData  out  XLEN  extended load result; 0 for stores and errors.
- RespErr  out  1  illegal request.
- MemReq  out  1  memory beat request.
- MemWe  out  1  beat is a write.
- MemAddr  out  ADDR_W  W-aligned beat address.
- MemWData  out  XLEN  lane-steered write data, little-endian lanes.
- MemWMask  out  W  byte-lane enables, bit i = byte lane i.
- MemAck  in  1  beat complete; MemRData is valid in the same cycle.
- MemRData  in  XLEN  read data, little-endian lanes.

## Operation
- States:
  - IDLE: ReqReady=1.
  - BEAT0: MemReq=1.
  - BEAT1: MemReq=1.
  - RESP: RespValid=1.
- Accept on ReqValid&&ReqReady. Addr, op, data and direction are registered at accept.
- Size S is 1, 2, 4 or 8 bytes. Offset O = Addr mod W.
- Illegal request conditions:
  - MemRd==MemWr.
  - Store with MemOp 1xx.
  - MemOp 111.
  - MemOp 011 or 110 when XLEN=32.
- Illegal request behaviour: IDLE goes directly to RESP with RespErr=1 and RData=0. No MemReq is issued.
- Split rule: if O+S > W the access crosses a word boundary.
  - BEAT0 covers lanes O..W-1 at address Addr-O.
  - BEAT1 covers lanes 0..(O+S-W-1) at address Addr-O+W.
  - Otherwise only BEAT0 is issued, covering lanes O..O+S-1.
- Beat handshake:
  - MemReq, MemWe, MemAddr, MemWData and MemWMask are held stable until MemAck.
  - Advance on MemAck: BEAT0→BEAT1 when split, else BEAT0→RESP; BEAT1→RESP.
- Loads:
  - On each ack, the acked lanes are captured into a 2W-byte assembly buffer.
  - The result is the S bytes starting at buffer byte O, sign-extended (MemOp 0xx) or zero-extended (1xx) to XLEN.
  - For XLEN=32, LW needs no extension. For XLEN=64, LW sign-extends and LWU zero-extends.
- Stores: MemWData places WData byte k at lane (O+k) mod W. MemWMask covers exactly the written lanes. RData=0.
- RESP→IDLE on RespReady.
- Reset mid-operation: state returns to IDLE immediately. MemAck arriving after reset, or while in IDLE or RESP, is ignored.

## Timing
- Reset values:
  - ReqReady=1.
  - RespValid=0, RespErr=0, RData=0.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemWMask=0.
- All outputs are registered or decoded from state only. No combinational path runs from any input to any output.
- Latency with zero-wait memory (MemAck in the first MemReq cycle):
  - Accept at edge 0. MemReq high in cycle 1. RespValid high in cycle 2.
  - A split access adds one cycle.
  - Each cycle MemAck is low adds one cycle.
- ReqReady is low from the cycle after accept until the cycle after the RespValid&&RespReady handshake. Back-to-back throughput is one request per 3 cycles minimum.
- RespValid, RData and RespErr are stable while RespReady is low.

## Test plan
- Aligned LW at 0x80000004, XLEN=32, MemRData=0x12345678, zero-wait ack:
  - One beat at 0x80000004.
  - RespValid in cycle 2, RData=0x12345678.
- LB at 0x80000003 with word 0x80AABBCC: RData=0xFFFFFF80. LBU at the same address: RData=0x00000080.
- Misaligned LW at 0x80000006:
  - Beat0 at 0x80000004 returns 0x44332211. Beat1 at 0x80000008 returns 0x88776655.
  - RData=0x66554433. RespValid in cycle 3.
- SH 0xBEEF at 0x80000003:
  - Beat0: MemAddr 0x80000000, MemWMask 1000, MemWData 0xEF000000.
  - Beat1: MemAddr 0x80000004, MemWMask 0001, MemWData 0x000000BE.
  - Response has RData=0.
- Error and backpressure:
  - MemOp 011 on XLEN=32 gives RespErr=1 and no MemReq.
  - With RespReady held low for 5 cycles, RespValid, RData and RespErr stay stable and ReqReady stays 0.
- Rst pulsed while in BEAT0 waiting for ack:
  - MemReq drops asynchronously; an ack 2 cycles later is ignored.
  - ReqReady=1 after release; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem.sv
// Load/store unit: steers store lanes, extends load data, splits word-crossing accesses into two beats.
// Latency: request accepted at edge 0, first beat in cycle 1, response in cycle 2 (+1 if split, +1 per wait cycle).
// Backpressure: ReqReady only in IDLE; beats held until MemAck; response held until RespReady.
module lsu_mem #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [2:0]        MemOp,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [XLEN-1:0]   WData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [XLEN-1:0]   RData,
    output logic              RespErr,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [XLEN-1:0]   MemWData,
    output logic [XLEN/8-1:0] MemWMask,
    input  logic              MemAck,
    input  logic [XLEN-1:0]   MemRData
);

    localparam int W  = XLEN / 8;
    localparam int OW = $clog2(W);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [2:0]      op_q;
    logic [OW-1:0]   off_q;
    logic            wr_q;
    logic            split_q;
    logic [XLEN-1:0] wdata1_q;
    logic [W-1:0]    mask1_q;
    logic [XLEN-1:0] buf_lo_q;

    logic [OW-1:0]     req_off;
    logic [3:0]        req_size;
    logic              req_illegal;
    logic              req_split;
    logic [XLEN-1:0]   wdata_trim;
    logic [W-1:0]      size_mask;
    logic [2*XLEN-1:0] wide_data;
    logic [2*W-1:0]    wide_mask;

    logic [2*XLEN-1:0] asm_buf;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_result;
    logic              sign_bit;

    assign ReqReady  = (state == S_IDLE);
    assign RespValid = (state == S_RESP);
    assign MemReq    = (state == S_BEAT0) || (state == S_BEAT1);

    // Decode the incoming request and steer store bytes/lane enables across a two-word window
    always_comb begin
        req_off     = Addr[OW-1:0];
        req_size    = 4'd1 << MemOp[1:0];
        req_illegal = (MemRd == MemWr) || (MemWr && MemOp[2]) || (MemOp == 3'b111) ||
                      ((XLEN == 32) && ((MemOp == 3'b011) || (MemOp == 3'b110)));
        req_split   = (int'(req_off) + int'(req_size)) > W;
        wdata_trim  = '0;
        size_mask   = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(req_size)) begin
                size_mask[i]         = 1'b1;
                wdata_trim[i*8 +: 8] = MemWr ? WData[i*8 +: 8] : 8'h00;
            end
        end
        wide_data = {{XLEN{1'b0}}, wdata_trim} << {req_off, 3'b000};
        wide_mask = {{W{1'b0}}, size_mask} << req_off;
    end

    // Assemble the load result from the captured low word and the word on the bus this cycle
    always_comb begin
        asm_buf = {MemRData, (state == S_BEAT0) ? MemRData : buf_lo_q};
        shifted = XLEN'(asm_buf >> {off_q, 3'b000});
        case (op_q[1:0])
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
        if (op_q[2]) begin
            sign_bit = 1'b0;
        end
        load_result = '0;
        for (int i = 0; i < W; i++) begin
            if (i < (1 << op_q[1:0])) begin
                load_result[i*8 +: 8] = shifted[i*8 +: 8];
            end else begin
                load_result[i*8 +: 8] = {8{sign_bit}};
            end
        end
    end

    // Request accept, beat sequencing and response capture
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            off_q    <= '0;
            wr_q     <= 1'b0;
            split_q  <= 1'b0;
            wdata1_q <= '0;
            mask1_q  <= '0;
            buf_lo_q <= '0;
            RData    <= '0;
            RespErr  <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWMask <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ReqValid) begin
                        if (req_illegal) begin
                            state   <= S_RESP;
                            RespErr <= 1'b1;
                            RData   <= '0;
                        end else begin
                            state    <= S_BEAT0;
                            op_q     <= MemOp;
                            off_q    <= req_off;
                            wr_q     <= MemWr;
                            split_q  <= req_split;
                            wdata1_q <= wide_data[2*XLEN-1:XLEN];
                            mask1_q  <= wide_mask[2*W-1:W];
                            MemWe    <= MemWr;
                            MemAddr  <= {Addr[ADDR_W-1:OW], {OW{1'b0}}};
                            MemWData <= wide_data[XLEN-1:0];
                            MemWMask <= wide_mask[W-1:0];
                        end
                    end
                end
                S_BEAT0: begin
                    if (MemAck) begin
                        buf_lo_q <= MemRData;
                        if (split_q) begin
                            state    <= S_BEAT1;
                            MemAddr  <= MemAddr + WORD_BYTES;
                            MemWData <= wdata1_q;
                            MemWMask <= mask1_q;
                        end else begin
                            state <= S_RESP;
                            RData <= wr_q ? '0 : load_result;
                        end
                    end
                end
                S_BEAT1: begin
                    if (MemAck) begin
                        state <= S_RESP;
                        RData <= wr_q ? '0 : load_result;
                    end
                end
                default: begin
                    if (RespReady) begin
                        state   <= S_IDLE;
                        RData   <= '0;
                        RespErr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              ReqValid;
    logic              ReqReady;
    logic              MemRd;
    logic              MemWr;
    logic [2:0]        MemOp;
    logic [ADDR_W-1:0] Addr;
    logic [XLEN-1:0]   WData;
    logic              RespValid;
    logic              RespReady;
    logic [XLEN-1:0]   RData;
    logic              RespErr;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [XLEN-1:0]   MemWData;
    logic [3:0]        MemWMask;
    logic              MemAck;
    logic [XLEN-1:0]   MemRData;

    lsu_mem #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp), .Addr(Addr), .WData(WData),
        .RespValid(RespValid), .RespReady(RespReady), .RData(RData), .RespErr(RespErr),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWMask(MemWMask), .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Memory seen by the DUT, and the reference memory updated by the model
    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];

    int          n_beats;
    int          req_cycle;
    int          resp_cycle;
    logic [31:0] b_addr [0:3];
    logic [31:0] b_data [0:3];
    logic [3:0]  b_mask [0:3];
    logic        b_we   [0:3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = mem[8'(a[7:0] + 8'(i))];
        return v;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[8'(a[7:0] + 8'(i))]     = w[i*8 +: 8];
            ref_mem[8'(a[7:0] + 8'(i))] = w[i*8 +: 8];
        end
    endtask

    function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] op);
        return (rd == wr) || (wr && op[2]) || (op == 3'd7) || (op == 3'd3) || (op == 3'd6);
    endfunction

    // Little-endian gather of S bytes from the reference memory, then extension
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a);
        int s;
        logic [31:0] v;
        s = 1 << op[1:0];
        v = '0;
        for (int k = 0; k < s; k++) v[k*8 +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
        if (!op[2] && s < 4 && v[s*8-1]) begin
            for (int k = s; k < 4; k++) v[k*8 +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic apply_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        for (int k = 0; k < (1 << op[1:0]); k++) ref_mem[8'(a[7:0] + 8'(k))] = wd[k*8 +: 8];
    endtask

    // Expected beats from the set of bytes touched: word address, lane enables, lane data
    task automatic check_beats(input logic wr, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] wd);
        int s, nb, idx, lane;
        logic [31:0] base, ba;
        logic [31:0] ed [0:1];
        logic [3:0]  em [0:1];
        s = 1 << op[1:0];
        base = a & ~32'h3;
        nb = 1;
        ed[0] = '0; ed[1] = '0; em[0] = '0; em[1] = '0;
        for (int k = 0; k < s; k++) begin
            ba   = a + 32'(k);
            idx  = ((ba & ~32'h3) != base) ? 1 : 0;
            lane = int'(ba[1:0]);
            if (idx == 1) nb = 2;
            em[idx][lane] = 1'b1;
            ed[idx][lane*8 +: 8] = wd[k*8 +: 8];
        end
        chk("beat_count", 64'(n_beats), 64'(nb));
        for (int i = 0; i < nb && i < n_beats; i++) begin
            chk("beat_addr", b_addr[i], base + 32'(4*i));
            chk("beat_we", b_we[i], wr);
            if (wr) begin
                chk("beat_mask", b_mask[i], em[i]);
                chk("beat_wdata", b_data[i], ed[i]);
            end
        end
    endtask

    // Issue one request, act as the memory with 'waits' stall cycles per beat, hold the response
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input int resp_wait,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int c, wc;
        n_beats = 0; req_cycle = -1; resp_cycle = -1; wc = 0;
        c = 0;
        while (!ReqReady && c < 20) begin
            @(posedge Clk); #1; c++;
        end
        chk("req_ready_idle", ReqReady, 1'b1);
        ReqValid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; Addr = a; WData = wd;
        @(posedge Clk); #1;
        ReqValid = 1'b0; Addr = $urandom; WData = $urandom; MemOp = 3'($urandom);
        c = 1;
        while (!RespValid && c < 60) begin
            MemAck = 1'b0;
            if (MemReq) begin
                if (req_cycle < 0) req_cycle = c;
                if (wc < waits) begin
                    wc++;
                end else begin
                    MemAck   = 1'b1;
                    MemRData = rd_word(MemAddr);
                    if (n_beats < 4) begin
                        b_addr[n_beats] = MemAddr; b_data[n_beats] = MemWData;
                        b_mask[n_beats] = MemWMask; b_we[n_beats]   = MemWe;
                    end
                    if (MemWe) begin
                        for (int i = 0; i < 4; i++)
                            if (MemWMask[i]) mem[8'(MemAddr[7:0] + 8'(i))] = MemWData[i*8 +: 8];
                    end
                    n_beats++;
                    wc = 0;
                end
            end
            @(posedge Clk); #1; c++;
        end
        MemAck = 1'b0; MemRData = $urandom;
        chk("resp_valid_seen", RespValid, 1'b1);
        resp_cycle = c;
        for (int i = 0; i <= resp_wait; i++) begin
            chk("resp_valid_hold", RespValid, 1'b1);
            chk("resp_rdata", RData, exp_rdata);
            chk("resp_err", RespErr, exp_err);
            chk("req_ready_busy", ReqReady, 1'b0);
            if (i < resp_wait) begin
                @(posedge Clk); #1;
            end
        end
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;
        chk("req_ready_after_resp", ReqReady, 1'b1);
        chk("resp_valid_dropped", RespValid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd, wr, ill;
        logic [2:0] op;
        logic [31:0] a, wd, er;
        int r, waits, rw, nb;

        Rst = 1'b1; ReqValid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = '0;
        Addr = '0; WData = '0; RespReady = 1'b0; MemAck = 1'b0; MemRData = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        @(posedge Clk); #1;
        chk("rst_req_ready", ReqReady, 1'b1);
        chk("rst_resp_valid", RespValid, 1'b0);
        chk("rst_resp_err", RespErr, 1'b0);
        chk("rst_rdata", RData, 0);
        chk("rst_mem_req", MemReq, 1'b0);
        chk("rst_mem_we", MemWe, 1'b0);
        chk("rst_mem_addr", MemAddr, 0);
        chk("rst_mem_wdata", MemWData, 0);
        chk("rst_mem_wmask", MemWMask, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Aligned LW, zero-wait
        set_word(32'h80000004, 32'h12345678);
        run_op(1, 0, 3'b010, 32'h80000004, 0, 0, 0, 32'h12345678, 0);
        chk("lw_beats", 64'(n_beats), 1);
        chk("lw_beat_addr", b_addr[0], 32'h80000004);
        chk("lw_req_cycle", 64'(req_cycle), 1);
        chk("lw_resp_cycle", 64'(resp_cycle), 2);

        // LB / LBU sign and zero extension
        set_word(32'h80000000, 32'h80AABBCC);
        run_op(1, 0, 3'b000, 32'h80000003, 0, 0, 0, 32'hFFFFFF80, 0);
        run_op(1, 0, 3'b100, 32'h80000003, 0, 1, 0, 32'h00000080, 0);

        // Misaligned LW split over two words
        set_word(32'h80000004, 32'h44332211);
        set_word(32'h80000008, 32'h88776655);
        run_op(1, 0, 3'b010, 32'h80000006, 0, 0, 0, 32'h66554433, 0);
        chk("mlw_resp_cycle", 64'(resp_cycle), 3);
        chk("mlw_beats", 64'(n_beats), 2);
        chk("mlw_b0_addr", b_addr[0], 32'h80000004);
        chk("mlw_b1_addr", b_addr[1], 32'h80000008);

        // Split SH
        run_op(0, 1, 3'b001, 32'h80000003, 32'h0000BEEF, 0, 0, 0, 0);
        apply_store(3'b001, 32'h80000003, 32'h0000BEEF);
        chk("sh_beats", 64'(n_beats), 2);
        chk("sh_b0_addr", b_addr[0], 32'h80000000);
        chk("sh_b0_mask", b_mask[0], 4'b1000);
        chk("sh_b0_data", b_data[0], 32'hEF000000);
        chk("sh_b1_addr", b_addr[1], 32'h80000004);
        chk("sh_b1_mask", b_mask[1], 4'b0001);
        chk("sh_b1_data", b_data[1], 32'h000000BE);
        run_op(1, 0, 3'b010, 32'h80000000, 0, 0, 0, exp_load(3'b010, 32'h80000000), 0);

        // Illegal LD on XLEN=32 with response backpressure
        run_op(1, 0, 3'b011, 32'h80000010, 0, 0, 5, 0, 1);
        chk("err_no_beats", 64'(n_beats), 0);
        chk("err_resp_cycle", 64'(resp_cycle), 1);

        // Reset while waiting for the first beat's ack
        ReqValid = 1'b1; MemRd = 1'b1; MemWr = 1'b0; MemOp = 3'b010; Addr = 32'h80000010;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("rst_mid_memreq_before", MemReq, 1'b1);
        @(posedge Clk); #2;
        Rst = 1'b1;
        #1;
        chk("rst_mid_memreq_async", MemReq, 1'b0);
        chk("rst_mid_req_ready", ReqReady, 1'b1);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        MemAck = 1'b1; MemRData = 32'hDEADBEEF;
        @(posedge Clk); #1;
        MemAck = 1'b0;
        chk("late_ack_memreq", MemReq, 1'b0);
        chk("late_ack_resp_valid", RespValid, 1'b0);
        chk("late_ack_req_ready", ReqReady, 1'b1);
        run_op(1, 0, 3'b010, 32'h80000010, 0, 0, 0, exp_load(3'b010, 32'h80000010), 0);
        chk("post_rst_resp_cycle", 64'(resp_cycle), 2);

        // Randomized mix checked against the byte-level model
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rd = 1'($urandom); wr = rd;
            end else begin
                rd = (r < 6); wr = !rd;
            end
            op    = 3'($urandom_range(0, 7));
            a     = 32'h80000000 + 32'($urandom_range(0, 224));
            wd    = $urandom;
            waits = $urandom_range(0, 2);
            rw    = $urandom_range(0, 2);
            ill   = is_illegal(rd, wr, op);
            er    = (ill || wr) ? 32'h0 : exp_load(op, a);
            nb    = ((int'(a[1:0]) + (1 << op[1:0])) > 4) ? 2 : 1;
            run_op(rd, wr, op, a, wd, waits, rw, er, ill);
            if (ill) begin
                chk("rnd_err_no_beats", 64'(n_beats), 0);
            end else begin
                check_beats(wr, op, a, wd);
                chk("rnd_resp_cycle", 64'(resp_cycle), 64'(nb * (1 + waits) + 1));
                if (wr) apply_store(op, a, wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
